// File: rtl/jtopl_sh_tap.sv
// jtopl_sh_tap: clock-enabled delay line with runtime tap, flush, slot counter and primed flag.
module jtopl_sh_tap #(
    parameter int WIDTH = 5,
    parameter int STAGES = 18,
    parameter logic [WIDTH-1:0] RSTVAL = {WIDTH{1'b0}},
    parameter int SW = $clog2(STAGES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic [SW-1:0]    sel,
    output logic [WIDTH-1:0] tap,
    output logic [WIDTH-1:0] drop,
    output logic [SW-1:0]    slot,
    output logic             primed
);
    localparam int FW = $clog2(STAGES + 1);
    localparam logic [SW-1:0] LAST = SW'(STAGES - 1);
    localparam logic [FW-1:0] FULL = FW'(STAGES);

    generate
        if (STAGES < 3) begin : g_bad_stages
            $error("jtopl_sh_tap: STAGES must be at least 3");
        end
    endgenerate

    logic [WIDTH-1:0] stage [STAGES];
    logic [FW-1:0]    fill;

    // out-of-range selects clamp to the last stage so tap never wraps or goes X
    assign tap    = stage[sel > LAST ? LAST : sel];
    assign drop   = stage[STAGES-1];
    assign primed = fill == FULL;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) stage[k] <= RSTVAL;
            slot <= '0;
            fill <= '0;
        end else if (clr) begin
            // slot is left alone so the ring stays aligned across a flush
            for (int k = 0; k < STAGES; k++) stage[k] <= RSTVAL;
            fill <= '0;
        end else if (cen) begin
            stage[0] <= din;
            for (int k = 1; k < STAGES; k++) stage[k] <= stage[k-1];
            slot <= slot == LAST ? '0 : slot + 1'b1;
            fill <= fill == FULL ? FULL : fill + 1'b1;
        end
    end
endmodule

// File: tb/tb_jtopl_sh_tap.sv
// tb_jtopl_sh_tap: directed checks of reset, fill latency, tap select, cen gaps, flush and reset priority.
module tb_jtopl_sh_tap;
    localparam logic [4:0] RV = 5'b10101;

    logic       clk = 0;
    logic       rst = 0;
    logic       cen = 0;
    logic       clr = 0;
    logic [4:0] din = 0;
    logic [4:0] sel = 0;
    logic [4:0] tap, drop, slot;
    logic       primed;
    int total = 0;
    int bad = 0;

    jtopl_sh_tap #(.WIDTH(5), .STAGES(18), .RSTVAL(RV)) dut (
        .clk(clk), .rst(rst), .cen(cen), .clr(clr), .din(din), .sel(sel),
        .tap(tap), .drop(drop), .slot(slot), .primed(primed)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic c, input logic e, input logic [4:0] d);
        rst = r; clr = c; cen = e; din = d;
        @(posedge clk);
        #1;
        rst = 0; clr = 0; cen = 0;
    endtask

    task automatic test_reset;
        sel = 0;
        step(1, 0, 0, 5'd3);
        for (int c = 0; c < 6; c++) begin
            total++; if (drop !== RV) begin bad++; $display("FAIL reset_drop cyc%0d got=%b exp=%b", c, drop, RV); end
            total++; if (tap !== RV) begin bad++; $display("FAIL reset_tap cyc%0d got=%b exp=%b", c, tap, RV); end
            total++; if (slot !== 5'd0) begin bad++; $display("FAIL reset_slot cyc%0d got=%0d exp=0", c, slot); end
            total++; if (primed !== 1'b0) begin bad++; $display("FAIL reset_primed cyc%0d got=%b exp=0", c, primed); end
            if (c < 5) step(0, 0, 0, 5'd9);
        end
    endtask

    task automatic test_fill;
        sel = 0;
        for (int k = 1; k <= 18; k++) begin
            step(0, 0, 1, 5'(k));
            if (k < 18) begin
                total++; if (drop !== RV) begin bad++; $display("FAIL fill_drop e%0d got=%b exp=%b", k, drop, RV); end
                total++; if (primed !== 1'b0) begin bad++; $display("FAIL fill_primed e%0d got=%b exp=0", k, primed); end
            end
        end
        total++; if (drop !== 5'd1) begin bad++; $display("FAIL fill_drop18 got=%0d exp=1", drop); end
        total++; if (primed !== 1'b1) begin bad++; $display("FAIL fill_primed18 got=%b exp=1", primed); end
        total++; if (slot !== 5'd0) begin bad++; $display("FAIL fill_slotwrap got=%0d exp=0", slot); end
        step(0, 0, 1, 5'd19);
        total++; if (drop !== 5'd2) begin bad++; $display("FAIL fill_drop19 got=%0d exp=2", drop); end
    endtask

    task automatic test_tap;
        for (int k = 20; k <= 23; k++) begin
            step(0, 0, 1, 5'(k));
            sel = 0;  #1;
            total++; if (tap !== 5'(k)) begin bad++; $display("FAIL tap_sel0 e%0d got=%0d exp=%0d", k, tap, k); end
            sel = 5;  #1;
            total++; if (tap !== 5'(k - 5)) begin bad++; $display("FAIL tap_sel5 e%0d got=%0d exp=%0d", k, tap, k - 5); end
            sel = 17; #1;
            total++; if (tap !== 5'(k - 17) || tap !== drop) begin bad++; $display("FAIL tap_sel17 e%0d got=%0d exp=%0d", k, tap, k - 17); end
            sel = 31; #1;
            total++; if (tap !== 5'(k - 17)) begin bad++; $display("FAIL tap_sel31 e%0d got=%0d exp=%0d", k, tap, k - 17); end
            sel = 0;
        end
    endtask

    task automatic test_cen_gaps;
        int n;
        n = 0;
        sel = 0;
        step(1, 0, 0, 5'd0);
        for (int c = 1; c <= 54; c++) begin
            if (c % 3 == 0) begin
                n++;
                step(0, 0, 1, 5'(n));
            end else begin
                step(0, 0, 0, 5'd31);
            end
            total++; if (slot !== 5'(n % 18)) begin bad++; $display("FAIL gap_slot c%0d got=%0d exp=%0d", c, slot, n % 18); end
            total++; if (primed !== (n >= 18)) begin bad++; $display("FAIL gap_primed c%0d got=%b exp=%b", c, primed, n >= 18); end
            total++; if (drop !== (n >= 18 ? 5'(n - 17) : RV)) begin bad++; $display("FAIL gap_drop c%0d got=%0d", c, drop); end
            total++; if (tap !== (n > 0 ? 5'(n) : RV)) begin bad++; $display("FAIL gap_tap c%0d got=%0d", c, tap); end
        end
    endtask

    task automatic test_clr;
        step(1, 0, 0, 5'd0);
        for (int k = 1; k <= 25; k++) step(0, 0, 1, 5'(k));
        total++; if (slot !== 5'd7 || primed !== 1'b1) begin bad++; $display("FAIL clr_setup slot=%0d primed=%b exp slot=7 primed=1", slot, primed); end
        for (int c = 0; c < 2; c++) begin
            step(0, 1, 1, 5'd30);
            sel = 0; #1;
            total++; if (tap !== RV) begin bad++; $display("FAIL clr_tap0 c%0d got=%b exp=%b", c, tap, RV); end
            sel = 5; #1;
            total++; if (tap !== RV) begin bad++; $display("FAIL clr_tap5 c%0d got=%b exp=%b", c, tap, RV); end
            total++; if (drop !== RV) begin bad++; $display("FAIL clr_drop c%0d got=%b exp=%b", c, drop, RV); end
            total++; if (primed !== 1'b0) begin bad++; $display("FAIL clr_primed c%0d got=%b exp=0", c, primed); end
            total++; if (slot !== 5'd7) begin bad++; $display("FAIL clr_slot c%0d got=%0d exp=7", c, slot); end
        end
        sel = 0;
        for (int k = 1; k <= 18; k++) begin
            step(0, 0, 1, 5'(k));
            if (k < 18) begin
                total++; if (primed !== 1'b0 || drop !== RV) begin bad++; $display("FAIL refill e%0d primed=%b drop=%0d exp primed=0 drop=%0d", k, primed, drop, RV); end
            end
        end
        total++; if (primed !== 1'b1) begin bad++; $display("FAIL refill_primed got=%b exp=1", primed); end
        total++; if (drop !== 5'd1) begin bad++; $display("FAIL refill_drop got=%0d exp=1", drop); end
        total++; if (slot !== 5'd7) begin bad++; $display("FAIL refill_slot got=%0d exp=7", slot); end
    endtask

    task automatic test_rst_clr;
        step(0, 0, 1, 5'd19);
        step(0, 0, 1, 5'd20);
        total++; if (slot !== 5'd9) begin bad++; $display("FAIL rc_setup got=%0d exp=9", slot); end
        step(1, 1, 1, 5'd21);
        total++; if (slot !== 5'd0) begin bad++; $display("FAIL rc_slot got=%0d exp=0", slot); end
        total++; if (drop !== RV || tap !== RV) begin bad++; $display("FAIL rc_data drop=%b tap=%b exp=%b", drop, tap, RV); end
        total++; if (primed !== 1'b0) begin bad++; $display("FAIL rc_primed got=%b exp=0", primed); end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_tap;
        test_cen_gaps;
        test_clr;
        test_rst_clr;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
